dmem_responder: RTL and testbench

//  Data-memory responder for the MIPS core's load/store port. Accepts one word request
//  (valid/ready), waits a fixed number of wait states, then returns a response (valid/ready).

---
 rtl/dmem_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready word-memory responder with fixed wait states and byte-enable stores.
// Optional load/store access counters (rd_count, wr_count) are built when DMEM_ACCESS_CNT_EN is defined.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;

    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;

    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic        accept_s;
    logic        rsp_hs_s;
    logic        access_s;
    logic        acc_we_s;
    logic [31:0] acc_addr_s;
    logic [31:0] acc_wdata_s;
    logic [3:0]  acc_be_s;
    logic [31:0] offset_s;
    logic [31:0] word_off_s;
    logic [IDX_W-1:0] idx_s;
    logic        acc_err_s;
    logic        mem_we_s;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept_s = req_valid && req_ready_r;
    assign rsp_hs_s = rsp_valid_r && rsp_ready;

    // Access operands: with zero wait states the access happens on the accept edge, so use the live request
    always_comb begin
        acc_we_s    = we_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        acc_be_s    = be_r;
        if (state_r == ST_IDLE) begin
            acc_we_s    = req_we;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
            acc_be_s    = req_be;
        end else begin
            acc_we_s    = we_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_be_s    = be_r;
        end
    end

    // Address decode: the subtraction wraps, the lower-bound test uses the unwrapped compare
    always_comb begin
        offset_s   = acc_addr_s - BASE_ADDR;
        word_off_s = {2'b00, offset_s[31:2]};
        idx_s      = offset_s[IDX_W+1:2];
        acc_err_s  = (acc_addr_s[1:0] != 2'b00) ||
                     (acc_addr_s < BASE_ADDR) ||
                     (word_off_s >= 32'(DEPTH_WORDS));
    end

    // Next-state logic and the one-shot access strobe for the edge entering RESP
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        access_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt_s = ST_RESP;
                        access_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WAIT_LOAD;
                    end
                end else begin
                    cnt_nxt_s = 4'd0;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                    access_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, wait counter and handshake flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

    // Request capture on accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            be_r    <= 4'd0;
        end else if (accept_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            be_r    <= req_be;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            be_r    <= be_r;
        end
    end

    // Response data: loaded once by the access, held through back-pressure, cleared on handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else if (access_s) begin
            rsp_err_r   <= acc_err_s;
            rsp_rdata_r <= (acc_err_s || acc_we_s) ? 32'd0 : mem[idx_s];
        end else if (rsp_hs_s) begin
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
        end else begin
            rsp_err_r   <= rsp_err_r;
            rsp_rdata_r <= rsp_rdata_r;
        end
    end

    assign mem_we_s = reset && access_s && acc_we_s && !acc_err_s;

    // Storage array; contents survive reset, only enabled bytes are written
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be_s[b]) begin
                    mem[idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_count_r;
    logic [15:0] wr_count_r;

    // Saturating counts of completed non-error loads and stores
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_r <= 16'd0;
            wr_count_r <= 16'd0;
        end else if (rsp_hs_s && !rsp_err_r) begin
            if (we_r) begin
                wr_count_r <= (wr_count_r == 16'hFFFF) ? wr_count_r : wr_count_r + 16'd1;
                rd_count_r <= rd_count_r;
            end else begin
                rd_count_r <= (rd_count_r == 16'hFFFF) ? rd_count_r : rd_count_r + 16'd1;
                wr_count_r <= wr_count_r;
            end
        end else begin
            rd_count_r <= rd_count_r;
            wr_count_r <= wr_count_r;
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`endif

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic against a
// byte-addressed reference model. Two instances: WAIT_STATES=2 (index 0) and WAIT_STATES=0 (index 1).
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_count  [2];
    logic [15:0] wr_count  [2];
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_m [logic [32:0]];
    int rd_m [2];
    int wr_m [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef DMEM_ACCESS_CNT_EN
        , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef DMEM_ACCESS_CNT_EN
        , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit exp_err(input logic [31:0] a);
        longint unsigned ua;
        ua = a;
        if (ua % 4 != 0) return 1'b1;
        if (ua < BASE) return 1'b1;
        return ((ua - BASE) / 4) >= DEPTH;
    endfunction

    task automatic check_reset_vals(input int d);
        check_val("rst_req_ready", 32'(req_ready[d]), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check_val("rst_rsp_rdata", rsp_rdata[d], 32'd0);
        check_val("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
`ifdef DMEM_ACCESS_CNT_EN
        check_val("rst_rd_count", 32'(rd_count[d]), 32'd0);
        check_val("rst_wr_count", 32'(wr_count[d]), 32'd0);
`endif
    endtask

    // One complete transaction with optional response back-pressure, checked against the model
    task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int stall, output logic [31:0] rd);
        logic [32:0] key;
        bit          err_e;
        logic [31:0] exp_rd;
        logic [31:0] w;
        int          lat;
        key    = {d[0], addr};
        err_e  = exp_err(addr);
        exp_rd = 32'd0;
        if (!we && !err_e && mem_m.exists(key)) exp_rd = mem_m[key];
        @(negedge clk);
        check_val("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        rsp_ready[d] = (stall == 0);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom_range(0, 1));
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom_range(0, 15));
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("latency", 32'(lat), 32'(ws_of(d) + 1));
        check_val("rsp_err", 32'(rsp_err[d]), 32'(err_e));
        if (we || err_e || mem_m.exists(key)) check_val("rsp_rdata", rsp_rdata[d], exp_rd);
        check_val("req_ready_busy", 32'(req_ready[d]), 32'd0);
        rd = rsp_rdata[d];
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_val("hold_valid", 32'(rsp_valid[d]), 32'd1);
            check_val("hold_rdata", rsp_rdata[d], exp_rd);
            check_val("hold_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        check_val("idle_valid", 32'(rsp_valid[d]), 32'd0);
        check_val("idle_ready", 32'(req_ready[d]), 32'd1);
        check_val("idle_rdata", rsp_rdata[d], 32'd0);
        check_val("idle_err", 32'(rsp_err[d]), 32'd0);
        rsp_ready[d] = 1'b0;
        if (!err_e) begin
            if (we) begin
                w = mem_m.exists(key) ? mem_m[key] : 32'd0;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                end
                if (be == 4'hF || mem_m.exists(key)) mem_m[key] = w;
                wr_m[d]++;
            end else begin
                rd_m[d]++;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] pool [8];
        logic [31:0] bad  [6];
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; req_be[d] = 4'd0; rsp_ready[d] = 1'b0;
            rd_m[d] = 0; wr_m[d] = 0;
        end
        repeat (2) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        reset = 1'b1;

        // Store then load
        txn(0, 1'b1, 32'h10010004, 32'hDEADBEEF, 4'hF, 0, rd);
        txn(0, 1'b0, 32'h10010004, 32'd0, 4'h0, 0, rd);
        check_val("t1_rdata", rd, 32'hDEADBEEF);

        // Byte enables
        txn(0, 1'b1, 32'h10010008, 32'h11223344, 4'hF, 0, rd);
        txn(0, 1'b1, 32'h10010008, 32'hAABBCCDD, 4'b0101, 0, rd);
        txn(0, 1'b0, 32'h10010008, 32'd0, 4'h0, 0, rd);
        check_val("t2_rdata", rd, 32'h11BB33DD);

        // Errors leave the array alone, including the aliasing index 0 word
        txn(0, 1'b1, 32'h10010000, 32'h5A5A0001, 4'hF, 0, rd);
        txn(0, 1'b0, 32'h10010002, 32'd0, 4'h0, 0, rd);
        txn(0, 1'b0, 32'h0FFFFFFC, 32'd0, 4'h0, 0, rd);
        txn(0, 1'b0, 32'h10011000, 32'd0, 4'h0, 0, rd);
        txn(0, 1'b1, 32'h10011000, 32'hFFFFFFFF, 4'hF, 0, rd);
        txn(0, 1'b0, 32'h10010000, 32'd0, 4'h0, 0, rd);
        check_val("t3_unchanged", rd, 32'h5A5A0001);

        // Back-pressure for 5 cycles
        txn(0, 1'b0, 32'h10010004, 32'd0, 4'h0, 5, rd);

        // Reset in WAIT during a store
        txn(0, 1'b1, 32'h10010010, 32'hCAFEF00D, 4'hF, 0, rd);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10010010;
        req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals(0);
        rd_m[0] = 0; wr_m[0] = 0; rd_m[1] = 0; wr_m[1] = 0;
        @(negedge clk);
        reset = 1'b1;
        txn(0, 1'b0, 32'h10010010, 32'd0, 4'h0, 0, rd);
        check_val("t5_prior", rd, 32'hCAFEF00D);

        // Zero wait states and counters
        txn(1, 1'b1, 32'h10010020, 32'h01020304, 4'hF, 0, rd);
        txn(1, 1'b1, 32'h10010024, 32'hA0B0C0D0, 4'hF, 0, rd);
        txn(1, 1'b0, 32'h10010020, 32'd0, 4'h0, 0, rd);
        txn(1, 1'b0, 32'h10010024, 32'd0, 4'h0, 1, rd);
        txn(1, 1'b0, 32'h10010020, 32'd0, 4'h0, 0, rd);
        txn(1, 1'b0, 32'h10010021, 32'd0, 4'h0, 0, rd);
`ifdef DMEM_ACCESS_CNT_EN
        check_val("t6_rd_count", 32'(rd_count[1]), 32'd3);
        check_val("t6_wr_count", 32'(wr_count[1]), 32'd2);
`endif

        // Randomized traffic over a small word pool plus a set of bad addresses
        pool[0] = BASE;            pool[1] = BASE + 32'd4;
        pool[2] = BASE + 32'd8;    pool[3] = BASE + 32'd12;
        pool[4] = BASE + 32'hFF0;  pool[5] = BASE + 32'hFF4;
        pool[6] = BASE + 32'hFF8;  pool[7] = BASE + 32'hFFC;
        bad[0] = BASE + 32'd1;     bad[1] = BASE - 32'd4;
        bad[2] = BASE + 32'h1000;  bad[3] = 32'hFFFFFFFC;
        bad[4] = 32'h00000000;     bad[5] = BASE + 32'hFFE;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) txn(d, 1'b1, pool[i], $urandom, 4'hF, 0, rd);
        end
        for (int n = 0; n < 300; n++) begin
            int          d;
            bit          we;
            logic [31:0] a;
            d  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) a = bad[$urandom_range(0, 5)];
            else a = pool[$urandom_range(0, 7)];
            txn(d, we, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), rd);
        end
`ifdef DMEM_ACCESS_CNT_EN
        for (int d = 0; d < 2; d++) begin
            check_val("final_rd_count", 32'(rd_count[d]), 32'((rd_m[d] > 65535) ? 65535 : rd_m[d]));
            check_val("final_wr_count", 32'(wr_count[d]), 32'((wr_m[d] > 65535) ? 65535 : wr_m[d]));
        end
`endif
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) txn(d, 1'b0, pool[i], 32'd0, 4'h0, 0, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
